// File: rtl/ysyx_24100012_lsu.sv
// Load/store unit: ALU address + rs2 to a valid/ready data-memory port.
// Misaligned or illegal accesses finish locally with resp_err.
module ysyx_24100012_lsu #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wen,
  output logic [3:0]            mem_wmask,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } state_t;

  state_t state;

  logic [2:0]            f3_q;
  logic [1:0]            off_q;
  logic [1:0]            off;
  logic                  bad_f3;
  logic                  misal;
  logic                  acc_err;
  logic [3:0]            wmask;
  logic [DATA_WIDTH-1:0] wdata;
  logic [7:0]            ld_b;
  logic [15:0]           ld_h;
  logic [DATA_WIDTH-1:0] ld_data;

  assign off     = req_addr[1:0];
  assign acc_err = bad_f3 | misal;

  always_comb begin
    bad_f3 = 1'b0;
    misal  = 1'b0;
    wmask  = 4'b0000;
    wdata  = req_wdata;
    unique case (1'b1)
      req_funct3 == 3'b000: begin
        wmask = 4'b0001 << off;
        wdata = {4{req_wdata[7:0]}};
      end
      req_funct3 == 3'b001: begin
        misal = off[0];
        wmask = 4'b0011 << off;
        wdata = {2{req_wdata[15:0]}};
      end
      req_funct3 == 3'b010: begin
        misal = |off;
        wmask = 4'b1111;
      end
      req_funct3 == 3'b100: bad_f3 = req_wen;
      req_funct3 == 3'b101: begin
        bad_f3 = req_wen;
        misal  = off[0];
      end
      default: bad_f3 = 1'b1;
    endcase
    if (!req_wen) wmask = 4'b0000;
  end

  // Lane select from the full word returned by memory
  always_comb begin
    ld_b    = mem_rdata[{off_q, 3'b000} +: 8];
    ld_h    = mem_rdata[{off_q[1], 4'b0000} +: 16];
    ld_data = mem_rdata;
    unique case (1'b1)
      f3_q == 3'b000: ld_data = {{24{ld_b[7]}}, ld_b};
      f3_q == 3'b001: ld_data = {{16{ld_h[15]}}, ld_h};
      f3_q == 3'b100: ld_data = {24'b0, ld_b};
      f3_q == 3'b101: ld_data = {16'b0, ld_h};
      default:        ld_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_valid  <= 1'b0;
      mem_wen    <= 1'b0;
      mem_wmask  <= 4'b0000;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      f3_q       <= 3'b000;
      off_q      <= 2'b00;
    end else begin
      resp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            f3_q      <= req_funct3;
            off_q     <= off;
            mem_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
            mem_wen   <= req_wen;
            mem_wmask <= wmask;
            mem_wdata <= wdata;
            if (acc_err) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state     <= REQ;
              mem_valid <= 1'b1;
            end
          end
        end
        REQ: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= mem_wen ? '0 : ld_data;
          end
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24100012_lsu.sv
// Scoreboard bench for ysyx_24100012_lsu: byte-level reference model,
// randomized accesses, memory responder with waits and stray rvalid pulses.
module tb_ysyx_24100012_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  ysyx_24100012_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wen    (req_wen),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_wen    (mem_wen),
    .mem_wmask  (mem_wmask),
    .mem_wdata  (mem_wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          due;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [3:0]  mask;
    logic [31:0] wdata;
  } mreq_t;

  exp_t  q[$];
  mreq_t mq[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int rdy_wait = 0;
  int rv_wait  = 0;

  logic [7:0]  rmem [64];
  logic [31:0] wmem [16];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: byte-addressed memory, sizes and signedness from funct3
  function automatic void model(input logic wen, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic err, output logic [31:0] rd,
                                output logic [3:0] mask,
                                output logic [31:0] mwd);
    int n;
    int base;
    bit legal;
    logic [31:0] v;
    n     = 1 << f3[1:0];
    base  = int'(a[5:0]);
    legal = wen ? (f3 <= 3'd2)
                : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    err   = !legal || (int'(a[1:0]) % n != 0);
    rd    = 32'h0;
    mask  = 4'h0;
    mwd   = 32'h0;
    if (err) return;
    if (!wen) begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v |= 32'(rmem[base + i]) << (8 * i);
      if (!f3[2] && n < 4 && v[8 * n - 1]) v |= ~((32'd1 << (8 * n)) - 1);
      rd = v;
    end else begin
      mask = 4'(((1 << n) - 1) << a[1:0]);
      for (int i = 0; i < 4; i++) mwd[8 * i +: 8] = wd[8 * (i % n) +: 8];
      for (int i = 0; i < n; i++) rmem[base + i] = wd[8 * i +: 8];
    end
  endfunction

  task automatic set_word(input int idx, input logic [31:0] w);
    wmem[idx] = w;
    for (int i = 0; i < 4; i++) rmem[4 * idx + i] = w[8 * i +: 8];
  endtask

  task automatic issue(input logic wen, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int rw, input int vw, input bit want_resp);
    logic        err;
    logic [31:0] rd;
    logic [3:0]  mk;
    logic [31:0] mwd;
    int          n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_idle", req_ready, 1'b1);
    model(wen, f3, a, wd, err, rd, mk, mwd);
    rdy_wait = rw;
    rv_wait  = vw;
    if (!err) mq.push_back('{{a[31:2], 2'b00}, wen, mk, mwd});
    if (want_resp) q.push_back('{rd, err, cyc + (err ? 1 : 3 + rw + vw)});
    req_valid  = 1'b1;
    req_wen    = wen;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(negedge clk);
    req_valid  = 1'b0;
    req_addr   = $urandom;
    req_wdata  = $urandom;
    chk("req_ready_busy", req_ready, 1'b0);
  endtask

  // Memory responder
  task automatic serve();
    mreq_t e;
    int    rw;
    int    vw;
    int    idx;
    rw = rdy_wait;
    vw = rv_wait;
    if (mq.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_mem_valid: got 1 expected 0");
      e = '{mem_addr, mem_wen, mem_wmask, mem_wdata};
    end else begin
      e = mq.pop_front();
    end
    chk("mem_addr", mem_addr, e.addr);
    chk("mem_wen", mem_wen, e.wen);
    chk("mem_wmask", mem_wmask, e.mask);
    if (e.wen) chk("mem_wdata", mem_wdata, e.wdata);
    for (int i = 0; i < rw; i++) begin
      mem_ready  = 1'b0;
      mem_rvalid = 1'($urandom_range(1));
      mem_rdata  = $urandom;
      @(negedge clk);
      chk("hold_valid", mem_valid, 1'b1);
      chk("hold_addr", mem_addr, e.addr);
      chk("hold_mask", mem_wmask, e.mask);
      if (e.wen) chk("hold_wdata", mem_wdata, e.wdata);
    end
    mem_rvalid = 1'b0;
    mem_ready  = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    chk("wait_valid_low", mem_valid, 1'b0);
    for (int i = 0; i < vw; i++) @(negedge clk);
    idx = int'(e.addr[5:2]);
    if (e.wen) begin
      for (int i = 0; i < 4; i++)
        if (mem_wmask[i]) wmem[idx][8 * i +: 8] = mem_wdata[8 * i +: 8];
      mem_rdata = $urandom;
    end else begin
      mem_rdata = wmem[idx];
    end
    mem_rvalid = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0;
  endtask

  initial begin
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      mem_ready  = 1'b0;
      mem_rvalid = 1'b0;
      if (!rst && mem_valid) begin
        serve();
      end else if (!rst && $urandom_range(3) == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = $urandom;
      end
    end
  end

  // Response monitor
  exp_t me;
  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_resp: resp_valid got 1 expected 0");
      end else begin
        me = q.pop_front();
        chk("resp_rdata", resp_rdata, me.rd);
        chk("resp_err", resp_err, me.err);
        chk("resp_cycle", cyc, me.due);
      end
    end
  end

  initial begin
    int n;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_wen    = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    for (int i = 0; i < 16; i++) set_word(i, $urandom);
    set_word(0, 32'h80FF1234);
    set_word(1, 32'hDEADBEEF);
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_err", resp_err, 1'b0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_mem_valid", mem_valid, 1'b0);
    chk("rst_mem_wen", mem_wen, 1'b0);
    chk("rst_mem_wmask", mem_wmask, 4'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    rst = 1'b0;

    issue(1'b0, 3'b010, 32'h80000004, 32'h0, 0, 0, 1'b1);
    issue(1'b0, 3'b000, 32'h80000003, 32'h0, 0, 0, 1'b1);
    issue(1'b0, 3'b100, 32'h80000003, 32'h0, 0, 0, 1'b1);
    issue(1'b0, 3'b001, 32'h80000002, 32'h0, 0, 0, 1'b1);
    issue(1'b0, 3'b101, 32'h80000002, 32'h0, 0, 0, 1'b1);
    issue(1'b1, 3'b000, 32'h80000002, 32'h000000AB, 0, 0, 1'b1);
    issue(1'b1, 3'b001, 32'h80000002, 32'h00001234, 1, 1, 1'b1);
    issue(1'b0, 3'b010, 32'h80000000, 32'h0, 0, 0, 1'b1);
    issue(1'b0, 3'b010, 32'h80000002, 32'h0, 0, 0, 1'b1);
    issue(1'b0, 3'b011, 32'h80000000, 32'h0, 0, 0, 1'b1);
    issue(1'b1, 3'b100, 32'h80000000, 32'h5, 0, 0, 1'b1);
    issue(1'b0, 3'b010, 32'h80000004, 32'h0, 3, 2, 1'b1);

    // Reset while the LSU sits in WAIT; the late rvalid must be dropped
    issue(1'b0, 3'b010, 32'h80000008, 32'h0, 0, 4, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("post_rst_ready", req_ready, 1'b1);
    chk("post_rst_resp_valid", resp_valid, 1'b0);
    chk("post_rst_mem_valid", mem_valid, 1'b0);
    repeat (8) @(negedge clk);
    issue(1'b0, 3'b010, 32'h80000004, 32'h0, 0, 0, 1'b1);

    for (int k = 0; k < 200; k++) begin
      issue(1'($urandom_range(1)), 3'($urandom_range(7)),
            32'h80000000 | 32'($urandom_range(63)), $urandom,
            $urandom_range(3), $urandom_range(3), 1'b1);
    end

    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("pending_resp", q.size(), 0);
    chk("pending_mem", mq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
